position_stream_packer: RTL and testbench

POSITION_STREAM_PACKER -- requirements
Module: position_stream_packer

---
 rtl/position_stream_packer_if.sv | 23 ++
 rtl/position_stream_packer.sv | 187 ++++++++++++++++++
 tb/tb_position_stream_packer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/position_stream_packer_if.sv
// rtl/position_stream_packer_if.sv - output stream bundle for the position packer
interface position_stream_packer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/position_stream_packer.sv
// rtl/position_stream_packer.sv - packs tbt/fa/sa position records into 5-word stream packets
module position_stream_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [DATA_WIDTH-1:0] tbtX,
  input  logic [DATA_WIDTH-1:0] tbtY,
  input  logic [DATA_WIDTH-1:0] tbtQ,
  input  logic [DATA_WIDTH-1:0] tbtS,
  input  logic [DATA_WIDTH-1:0] faX,
  input  logic [DATA_WIDTH-1:0] faY,
  input  logic [DATA_WIDTH-1:0] faQ,
  input  logic [DATA_WIDTH-1:0] faS,
  input  logic [DATA_WIDTH-1:0] saX,
  input  logic [DATA_WIDTH-1:0] saY,
  input  logic [DATA_WIDTH-1:0] saQ,
  input  logic [DATA_WIDTH-1:0] saS,
  input  logic                  tbtToggle,
  input  logic                  faToggle,
  input  logic                  saToggle,
  input  logic [2:0]            enableMask,
  input  logic                  clearOverrun,
  position_stream_packer_if.master m_axis,
  output logic [2:0]            overrunFlags,
  output logic                  busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            toggles;
  logic [2:0]            change;
  logic [2:0]            capture;
  logic [2:0]            toggle_match_q, toggle_match_d;
  logic [2:0]            pending_q, pending_d;
  logic [2:0]            overrun_q, overrun_d;
  logic [2:0]            load_clr;
  logic                  load_en;
  logic [1:0]            sel_src;
  logic [DATA_WIDTH-1:0] header;
  logic [DATA_WIDTH-1:0] rec    [0:2][0:3];
  logic [DATA_WIDTH-1:0] hold_q [0:2][0:3];
  logic [DATA_WIDTH-1:0] hold_d [0:2][0:3];
  logic [DATA_WIDTH-1:0] obuf_q [0:4];
  logic [DATA_WIDTH-1:0] obuf_d [0:4];
  logic [15:0]           seq_q  [0:2];
  logic [15:0]           seq_d  [0:2];
  logic [2:0]            word_count_q, word_count_d;
  logic                  last_beat;

  assign toggles   = {saToggle, faToggle, tbtToggle};
  assign change    = toggles ^ toggle_match_q;
  assign capture   = change & enableMask;
  assign last_beat = (word_count_q == 3'd4);

  always_comb begin
    rec[0][0] = tbtX; rec[0][1] = tbtY; rec[0][2] = tbtQ; rec[0][3] = tbtS;
    rec[1][0] = faX;  rec[1][1] = faY;  rec[1][2] = faQ;  rec[1][3] = faS;
    rec[2][0] = saX;  rec[2][1] = saY;  rec[2][2] = saQ;  rec[2][3] = saS;
  end

  // Fixed priority tbt > fa > sa; the load only happens from IDLE.
  always_comb begin
    load_en = (state_q == ST_IDLE) && (|pending_q);
    sel_src = 2'd2;
    if (pending_q[0]) begin
      sel_src = 2'd0;
    end else if (pending_q[1]) begin
      sel_src = 2'd1;
    end
    load_clr = load_en ? (3'b001 << sel_src) : 3'b000;
    header = '0;
    header[DATA_WIDTH-1 -: 2] = sel_src;
    header[15:0] = seq_q[sel_src];
  end

  // A same-edge capture re-asserts pending after the load clears it, and the
  // load reads the old holding contents, so that case is not an overrun.
  always_comb begin
    toggle_match_d = toggles;
    pending_d      = ((pending_q & ~load_clr) | capture) & enableMask;
    overrun_d      = (clearOverrun ? 3'b000 : overrun_q) | (capture & pending_q & ~load_clr);
    for (int s = 0; s < 3; s++) begin
      seq_d[s] = capture[s] ? seq_q[s] + 16'd1 : seq_q[s];
      for (int w = 0; w < 4; w++) begin
        hold_d[s][w] = capture[s] ? rec[s][w] : hold_q[s][w];
      end
    end
    for (int w = 0; w < 5; w++) begin
      obuf_d[w] = obuf_q[w];
    end
    if (load_en) begin
      obuf_d[0] = header;
      for (int w = 0; w < 4; w++) begin
        obuf_d[w+1] = hold_q[sel_src][w];
      end
    end
  end

  // Toggle trackers reload from the live inputs so release never fakes a record.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      toggle_match_q <= toggles;
      pending_q      <= 3'b000;
      overrun_q      <= 3'b000;
      for (int s = 0; s < 3; s++) begin
        seq_q[s] <= 16'd0;
        for (int w = 0; w < 4; w++) begin
          hold_q[s][w] <= '0;
        end
      end
      for (int w = 0; w < 5; w++) begin
        obuf_q[w] <= '0;
      end
    end else begin
      toggle_match_q <= toggle_match_d;
      pending_q      <= pending_d;
      overrun_q      <= overrun_d;
      for (int s = 0; s < 3; s++) begin
        seq_q[s] <= seq_d[s];
        for (int w = 0; w < 4; w++) begin
          hold_q[s][w] <= hold_d[s][w];
        end
      end
      for (int w = 0; w < 5; w++) begin
        obuf_q[w] <= obuf_d[w];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      word_count_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          state_d      = ST_SEND;
          word_count_d = 3'd0;
        end
      end
      ST_SEND: begin
        if (m_axis.m_tready) begin
          if (last_beat) begin
            state_d      = ST_IDLE;
            word_count_d = 3'd0;
          end else begin
            word_count_d = word_count_q + 3'd1;
          end
        end
      end
      default: begin
        state_d      = ST_IDLE;
        word_count_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    m_axis.m_tvalid = 1'b0;
    m_axis.m_tlast  = 1'b0;
    m_axis.m_tdata  = '0;
    busy            = 1'b0;
    if (state_q == ST_SEND) begin
      m_axis.m_tvalid = 1'b1;
      m_axis.m_tlast  = last_beat;
      m_axis.m_tdata  = obuf_q[word_count_q];
      busy            = 1'b1;
    end
  end

  assign overrunFlags = overrun_q;

endmodule

// File: tb/tb_position_stream_packer.sv
// tb/tb_position_stream_packer.sv - directed bench for position_stream_packer
module tb_position_stream_packer;
  localparam int DW = 32;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int unsigned cyc;
  } beat_t;

  logic clk = 1'b0;
  logic resetN;
  logic [DW-1:0] tbtX, tbtY, tbtQ, tbtS;
  logic [DW-1:0] faX, faY, faQ, faS;
  logic [DW-1:0] saX, saY, saQ, saS;
  logic tbtToggle, faToggle, saToggle;
  logic [2:0] enableMask;
  logic clearOverrun;
  logic [2:0] overrunFlags;
  logic busy;

  int unsigned n_vec = 0;
  int unsigned n_miss = 0;
  int unsigned cyc = 0;
  beat_t beats[$];
  logic prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic prev_last = 1'b0;

  position_stream_packer_if #(.DATA_WIDTH(DW)) sif ();

  position_stream_packer #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .tbtX         (tbtX),
    .tbtY         (tbtY),
    .tbtQ         (tbtQ),
    .tbtS         (tbtS),
    .faX          (faX),
    .faY          (faY),
    .faQ          (faQ),
    .faS          (faS),
    .saX          (saX),
    .saY          (saY),
    .saQ          (saQ),
    .saS          (saS),
    .tbtToggle    (tbtToggle),
    .faToggle     (faToggle),
    .saToggle     (saToggle),
    .enableMask   (enableMask),
    .clearOverrun (clearOverrun),
    .m_axis       (sif.master),
    .overrunFlags (overrunFlags),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Beats are logged one half-cycle before the edge that transfers them.
  always @(negedge clk) begin
    if (prev_stall) begin
      check_val("stall_valid", 32'(sif.m_tvalid), 32'd1);
      check_val("stall_data", sif.m_tdata, prev_data);
      check_val("stall_last", 32'(sif.m_tlast), 32'(prev_last));
    end
    if (sif.m_tvalid && sif.m_tready) begin
      beats.push_back('{sif.m_tdata, sif.m_tlast, cyc});
    end
    prev_stall = sif.m_tvalid && !sif.m_tready;
    prev_data  = sif.m_tdata;
    prev_last  = sif.m_tlast;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick(2);
    resetN = 1'b1;
    tick(1);
    beats.delete();
  endtask

  task automatic set_rec(input int src, input logic [31:0] base);
    case (src)
      0: begin tbtX = base + 1; tbtY = base + 2; tbtQ = base + 3; tbtS = base + 4; end
      1: begin faX = base + 1; faY = base + 2; faQ = base + 3; faS = base + 4; end
      default: begin saX = base + 1; saY = base + 2; saQ = base + 3; saS = base + 4; end
    endcase
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check_val("beats_arrived", 32'(beats.size() >= n), 32'd1);
  endtask

  task automatic expect_pkt(input string tag, input logic [31:0] hdr, input logic [31:0] base,
                            output int unsigned hdr_cyc, output int unsigned last_cyc);
    logic [31:0] w [0:4];
    beat_t b;
    w[0] = hdr;
    for (int i = 1; i < 5; i++) w[i] = base + 32'(i);
    hdr_cyc = 0;
    last_cyc = 0;
    wait_beats(5, 60);
    for (int i = 0; i < 5; i++) begin
      if (beats.size() == 0) return;
      b = beats.pop_front();
      check_val($sformatf("%s_w%0d", tag, i), b.data, w[i]);
      check_val($sformatf("%s_last%0d", tag, i), 32'(b.last), 32'(i == 4));
      if (i == 0) hdr_cyc = b.cyc;
      if (i == 4) last_cyc = b.cyc;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned t0, h0, l0, h1, l1, h2, l2;
    resetN = 1'b0;
    {tbtX, tbtY, tbtQ, tbtS, faX, faY, faQ, faS, saX, saY, saQ, saS} = '0;
    tbtToggle = 1'b1;
    faToggle = 1'b0;
    saToggle = 1'b1;
    enableMask = 3'b111;
    clearOverrun = 1'b0;
    sif.m_tready = 1'b1;
    #3;
    check_val("rst_valid", 32'(sif.m_tvalid), 32'd0);
    check_val("rst_last", 32'(sif.m_tlast), 32'd0);
    check_val("rst_data", sif.m_tdata, 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ovr", 32'(overrunFlags), 32'd0);
    tick(2);
    resetN = 1'b1;
    tick(8);
    check_val("no_spurious", 32'(beats.size()), 32'd0);

    // Single tbt record, header two cycles after the toggle
    set_rec(0, 32'h0);
    t0 = cyc;
    tbtToggle = ~tbtToggle;
    expect_pkt("tbt1", 32'h0000_0001, 32'h0, h0, l0);
    check_val("latency", 32'(h0 - t0), 32'd2);
    tick(1);
    check_val("idle_busy", 32'(busy), 32'd0);

    // Three simultaneous records
    do_reset();
    set_rec(0, 32'h100);
    set_rec(1, 32'h200);
    set_rec(2, 32'h300);
    tbtToggle = ~tbtToggle;
    faToggle = ~faToggle;
    saToggle = ~saToggle;
    expect_pkt("p_tbt", 32'h0000_0001, 32'h100, h0, l0);
    expect_pkt("p_fa", 32'h4000_0001, 32'h200, h1, l1);
    expect_pkt("p_sa", 32'h8000_0001, 32'h300, h2, l2);
    check_val("gap_fa", 32'(h1 - l0), 32'd2);
    check_val("gap_sa", 32'(h2 - l1), 32'd2);

    // Overrun while the output is stalled
    do_reset();
    sif.m_tready = 1'b0;
    set_rec(0, 32'hA0);
    tbtToggle = ~tbtToggle;
    tick(3);
    check_val("stall_busy", 32'(busy), 32'd1);
    set_rec(0, 32'hB0);
    tbtToggle = ~tbtToggle;
    tick(1);
    set_rec(0, 32'hC0);
    tbtToggle = ~tbtToggle;
    tick(2);
    check_val("ovr_set", 32'(overrunFlags), 32'h1);
    sif.m_tready = 1'b1;
    expect_pkt("ovr_a", 32'h0000_0001, 32'hA0, h0, l0);
    expect_pkt("ovr_c", 32'h0000_0003, 32'hC0, h0, l0);
    clearOverrun = 1'b1;
    tick(1);
    clearOverrun = 1'b0;
    check_val("ovr_clr", 32'(overrunFlags), 32'h0);

    // Ready alternating every cycle
    do_reset();
    set_rec(1, 32'h50);
    faToggle = ~faToggle;
    for (int i = 0; i < 30; i++) begin
      sif.m_tready = ~sif.m_tready;
      tick(1);
    end
    sif.m_tready = 1'b1;
    expect_pkt("fa_alt", 32'h4000_0001, 32'h50, h0, l0);

    // Disabled source produces nothing, even after re-enable
    enableMask = 3'b011;
    saToggle = ~saToggle;
    tick(8);
    check_val("dis_none", 32'(beats.size()), 32'd0);
    enableMask = 3'b111;
    tick(8);
    check_val("reen_none", 32'(beats.size()), 32'd0);

    // Reset during beat 3
    do_reset();
    set_rec(0, 32'h70);
    tbtToggle = ~tbtToggle;
    wait_beats(2, 20);
    check_val("b3_valid", 32'(sif.m_tvalid), 32'd1);
    check_val("b3_data", sif.m_tdata, 32'h72);
    #2;
    resetN = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(sif.m_tvalid), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    tick(1);
    resetN = 1'b1;
    beats.delete();
    tick(10);
    check_val("post_rst_none", 32'(beats.size()), 32'd0);

    // Sequence wrap on fa
    do_reset();
    set_rec(1, 32'h60);
    for (int i = 0; i < 65535; i++) begin
      faToggle = ~faToggle;
      tick(1);
    end
    tick(30);
    check_val("flood_beats", 32'(beats.size() >= 5), 32'd1);
    if (beats.size() >= 5) begin
      check_val("fa_ffff", beats[beats.size() - 5].data, 32'h4000_FFFF);
    end
    beats.delete();
    faToggle = ~faToggle;
    expect_pkt("fa_wrap", 32'h4000_0000, 32'h60, h0, l0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
